loop_divider: RTL and testbench
===============================

LOOP_DIVIDER -- requirements
Module: loop_divider

Interface
REQ-001 SHALL have parameter DIV_W, default 6, width of the divide-ratio input.
REQ-002 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port div_n  input  DIV_W  requested divide ratio N, unsigned.
REQ-005 SHALL have port clko  output  1  divided clock, period N_eff clk cycles.
REQ-006 SHALL have port clkob  output  1  complement of clko.
REQ-007 SHALL have one clock; reset is synchronous and active-high.
REQ-008 SHALL have no complementary clock input; all edges are clk rising edges.

Function
REQ-009 SHALL clamp the effective ratio to N_eff = 2 when div_n is 0 or 1; otherwise N_eff = div_n (2..63).
REQ-010 SHALL hold an internal ratio register, loaded from clamped div_n during reset and on the terminal-count cycle only.
REQ-011 SHALL keep a phase counter 0..N_eff-1 that increments each non-reset cycle and wraps to 0 after N_eff-1 (terminal count).
REQ-012 SHALL assert clko (registered) for HI = ceil(N_eff/2) cycles, then deassert for LO = floor(N_eff/2) cycles, every period.
REQ-013 SHALL give 50% duty for even N_eff, and high one cycle longer than low for odd N_eff.
REQ-014 SHALL drive clko high on the first clk edge after rst falls; that edge is counter phase 0.
REQ-015 SHALL keep clkob the registered exact complement of clko at all times, with no skew cycle.
REQ-016 SHALL ignore a div_n change mid-period; the new ratio takes effect at the start of the next period (glitch-free, no runt pulse).
REQ-017 SHALL produce no output transition other than at phase 0 (rise) and phase HI (fall).

Reset
REQ-018 SHALL, while rst=1 at a clk edge, set counter=0, clko=0, clkob=1, and ratio register=clamped div_n.
REQ-019 SHALL abort the current period on an rst assertion mid-period at the next edge, with no completion of the pulse.
REQ-020 SHALL restart the period from phase 0 when rst deasserts.

Structure
REQ-021 SHALL place DIV_W default and minimum-ratio constant (2) in shared package loop_divider_pkg.
REQ-022 SHALL be implemented as one flat module with no sub-module; counter, ratio latch and output flops are inline.

Verification
REQ-023 SHALL cover: div_n=2, rst released -> clko 1,0,1,0…, period 2, clkob inverse.
REQ-024 SHALL cover: div_n=3 -> clko high 2 cycles, low 1 cycle, repeating; div_n=4 -> 2/2.
REQ-025 SHALL cover: div_n=23 -> high 12, low 11; div_n=13 -> high 7, low 6.
REQ-026 SHALL cover: div_n=0 and div_n=1 -> identical to div_n=2.
REQ-027 SHALL cover: div_n changed 5->17 at phase 1 -> current period completes as 3/2, next period is 9/8.
REQ-028 SHALL cover: rst pulsed at phase 4 of N=7 -> clko=0, clkob=1 next edge; first clko rise on the first edge after release.

Source files
------------

// File: rtl/loop_divider_pkg.sv
// loop_divider_pkg
//   Shared constants for the loop divider.
//   DIV_W_DEF : default width of the divide-ratio input
//   MIN_RATIO : smallest ratio the divider can produce (one high, one low)
package loop_divider_pkg;

  localparam int DIV_W_DEF = 6;
  localparam int MIN_RATIO = 2;

endpackage

// File: rtl/loop_divider.sv
// loop_divider
//   Programmable integer clock divider. The output clock is a registered
//   signal high for ceil(N/2) cycles and low for floor(N/2) cycles, where N
//   is div_n clamped to at least 2. A new ratio is only accepted on the last
//   cycle of a period, so ratio changes never produce a runt pulse.
//
// Ports
//   clk   : in  sole clock, rising edge
//   rst   : in  synchronous active-high reset
//   div_n : in  requested divide ratio (DIV_W bits, unsigned)
//   clko  : out divided clock
//   clkob : out registered complement of clko
module loop_divider
  import loop_divider_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] div_n,
  output logic             clko,
  output logic             clkob
);

  // cnt_q is the phase that the next non-reset edge represents; the output
  // flop takes the level belonging to that phase at the same edge.
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] ratio_q, ratio_d;
  logic             clko_q, clko_d;
  logic             clkob_q, clkob_d;

  logic [DIV_W-1:0] div_clamped;
  logic [DIV_W-1:0] hi_cnt;
  logic             term_cnt;

  assign div_clamped = (div_n < DIV_W'(MIN_RATIO)) ? DIV_W'(MIN_RATIO) : div_n;

  // ceil(N/2): odd ratios spend the extra cycle high.
  assign hi_cnt   = (ratio_q >> 1) + {{(DIV_W-1){1'b0}}, ratio_q[0]};
  assign term_cnt = (cnt_q == ratio_q - DIV_W'(1));

  always_comb begin
    cnt_d   = cnt_q + DIV_W'(1);
    ratio_d = ratio_q;
    clko_d  = (cnt_q < hi_cnt);
    clkob_d = ~clko_d;
    if (term_cnt) begin
      // Last cycle of the period: wrap and pick up the ratio for the next one.
      cnt_d   = '0;
      ratio_d = div_clamped;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      ratio_q <= div_clamped;
      clko_q  <= 1'b0;
      clkob_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      ratio_q <= ratio_d;
      clko_q  <= clko_d;
      clkob_q <= clkob_d;
    end
  end

  assign clko  = clko_q;
  assign clkob = clkob_q;

endmodule

// File: tb/tb_loop_divider.sv
// tb_loop_divider
//   Randomized and directed checks of loop_divider against a queue-based
//   model: each period is expanded into its list of output levels when it
//   starts, and the ratio for the following period is captured when the last
//   level of the current one is consumed.
module tb_loop_divider;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] div_n = 6'd2;
  logic       clko;
  logic       clkob;

  int n_cmp = 0;
  int n_mis = 0;

  loop_divider #(.DIV_W(6)) dut (
    .clk   (clk),
    .rst   (rst),
    .div_n (div_n),
    .clko  (clko),
    .clkob (clkob)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  bit   level_q[$];
  int   pend_n      = 2;
  bit   exp_clko    = 1'b0;
  bit   model_valid = 1'b0;

  function automatic int clamp_n(input int d);
    return (d < 2) ? 2 : d;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      level_q.delete();
      pend_n      = clamp_n(int'(div_n));
      exp_clko    = 1'b0;
      model_valid = 1'b1;
    end else if (model_valid) begin
      if (level_q.size() == 0) begin
        for (int k = 0; k < pend_n; k++)
          level_q.push_back(k < (pend_n + 1) / 2);
      end
      exp_clko = level_q.pop_front();
      if (level_q.size() == 0)
        pend_n = clamp_n(int'(div_n));
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (model_valid) begin
      n_cmp++;
      if (clko !== exp_clko) begin
        n_mis++;
        $display("FAIL model_clko t=%0t actual=%b required=%b", $time, clko, exp_clko);
      end
      n_cmp++;
      if (clkob !== !exp_clko) begin
        n_mis++;
        $display("FAIL model_clkob t=%0t actual=%b required=%b", $time, clkob, !exp_clko);
      end
    end
  end

  // ---------------- directed literal checks ----------------
  task automatic lit(input string name, input logic act, input logic req);
    n_cmp++;
    if (act !== req) begin
      n_mis++;
      $display("FAIL %s t=%0t actual=%b required=%b", name, $time, act, req);
    end
  endtask

  task automatic reset_with(input int n);
    @(negedge clk);
    div_n = 6'(n);
    rst   = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst   = 1'b0;
  endtask

  // Release reset with ratio n and compare clko against the literal pattern
  // (MSB first). Optionally change div_n right after sample chg_at.
  task automatic check_seq(input string name, input int n, input logic [63:0] pat,
                           input int len, input int chg_at, input int chg_val);
    reset_with(n);
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      lit(name, clko, pat[len-1-i]);
      lit({name, "_b"}, clkob, !pat[len-1-i]);
      if (i == chg_at) div_n = 6'(chg_val);
    end
    $display("seq %s n=%0d len=%0d done", name, n, len);
  endtask

  initial begin
    rst   = 1'b1;
    div_n = 6'd2;
    repeat (2) @(negedge clk);
    lit("reset_clko", clko, 1'b0);
    lit("reset_clkob", clkob, 1'b1);

    check_seq("n2",  2,  64'b101010, 6, -1, 0);
    check_seq("n3",  3,  64'b110110, 6, -1, 0);
    check_seq("n4",  4,  64'b11001100, 8, -1, 0);
    check_seq("n0",  0,  64'b101010, 6, -1, 0);
    check_seq("n1",  1,  64'b101010, 6, -1, 0);
    check_seq("n13", 13, 64'b1111111_000000_1, 14, -1, 0);
    check_seq("n23", 23, 64'b111111111111_00000000000_1, 24, -1, 0);
    check_seq("chg5to17", 5, 64'b11100_111111111_00000000_1, 23, 1, 17);

    // Reset pulsed at phase 4 of N=7.
    reset_with(7);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      lit("n7_pre", clko, 1'b1);
    end
    rst = 1'b1;
    @(negedge clk);
    lit("n7_abort_clko", clko, 1'b0);
    lit("n7_abort_clkob", clkob, 1'b1);
    rst = 1'b0;
    @(negedge clk);
    lit("n7_restart_clko", clko, 1'b1);
    lit("n7_restart_clkob", clkob, 1'b0);
    $display("seq n7_reset_abort done");

    // Randomized ratios, mid-period ratio changes and resets.
    for (int r = 0; r < 30; r++) begin
      int cyc;
      reset_with(int'($urandom_range(0, 63)));
      cyc = int'($urandom_range(50, 200));
      for (int c = 0; c < cyc; c++) begin
        @(negedge clk);
        rst = 1'b0;
        if ($urandom_range(0, 19) == 0) div_n = 6'($urandom_range(0, 63));
        if ($urandom_range(0, 299) == 0) rst = 1'b1;
      end
      $display("random round %0d cycles=%0d div_n=%0d", r, cyc, div_n);
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
